// File: rtl/alu_seq.sv
// Registered multicycle ALU with start/done handshake and iterative shift-add multiplier.
// Define ALU_SEQ_DIV_EN to add the unsigned restoring divider (DIVU/REMU).
module alu_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  src1_i,
  input  logic [WIDTH-1:0]  src2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WIDTH-1:0]  result_o,
  output logic              zero_o,
  output logic              ovf_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(4'b0100);
`ifdef ALU_SEQ_DIV_EN
  localparam logic [CTRL_W-1:0] OP_DIVU = CTRL_W'(4'b0101);
  localparam logic [CTRL_W-1:0] OP_REMU = CTRL_W'(4'b0011);
`endif

  typedef enum logic [0:0] {IDLE, MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             go_iter;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic [WIDTH-1:0] mcand_nxt;
  logic [WIDTH-1:0] iter_res;

`ifdef ALU_SEQ_DIV_EN
  logic             div_q;
  logic             div_r;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
`endif

  // Single-cycle datapath; also flags ops that need the iteration state
  always_comb begin
    sum     = src1_i + src2_i;
    diff    = src1_i - src2_i;
    sc_res  = '0;
    sc_ovf  = 1'b0;
    go_iter = 1'b0;
    case (ctrl_i)
      OP_AND: sc_res = src1_i & src2_i;
      OP_OR:  sc_res = src1_i | src2_i;
      OP_NOR: sc_res = ~(src1_i | src2_i);
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SLT: sc_res = WIDTH'($signed(src1_i) < $signed(src2_i));
      OP_MUL: go_iter = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU, OP_REMU: go_iter = 1'b1;
`endif
      default: ;
    endcase
  end

  // One iteration step: shift-add multiply, or restoring divide with acc as remainder
  always_comb begin
    mul_acc_nxt = acc + (mplier[0] ? mcand : '0);
    acc_nxt     = mul_acc_nxt;
    mplier_nxt  = mplier >> 1;
    mcand_nxt   = mcand << 1;
    iter_res    = mul_acc_nxt;
`ifdef ALU_SEQ_DIV_EN
    rem_sh  = {acc, mplier[WIDTH-1]};
    div_ge  = (rem_sh >= {1'b0, mcand});
    rem_nxt = div_ge ? WIDTH'(rem_sh - {1'b0, mcand}) : rem_sh[WIDTH-1:0];
    quo_nxt = {mplier[WIDTH-2:0], div_ge};
    if (div_q || div_r) begin
      acc_nxt    = rem_nxt;
      mplier_nxt = quo_nxt;
      mcand_nxt  = mcand;
      iter_res   = div_q ? quo_nxt : rem_nxt;
    end
`endif
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b1;
      ovf_o    <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q    <= 1'b0;
      div_r    <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (go_iter) begin
              state  <= MUL;
              busy_o <= 1'b1;
              acc    <= '0;
              mcand  <= src1_i;
              mplier <= src2_i;
              cnt    <= '0;
`ifdef ALU_SEQ_DIV_EN
              div_q  <= (ctrl_i == OP_DIVU);
              div_r  <= (ctrl_i == OP_REMU);
              if (ctrl_i == OP_DIVU || ctrl_i == OP_REMU) begin
                mcand  <= src2_i;
                mplier <= src1_i;
              end
`endif
            end else begin
              result_o <= sc_res;
              zero_o   <= (sc_res == '0);
              ovf_o    <= sc_ovf;
              done_o   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            result_o <= iter_res;
            zero_o   <= (iter_res == '0);
            ovf_o    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
